cpu_bus_arbiter: RTL
====================

# cpu_bus_arbiter

Shares the single CPU memory bus between the instruction-fetch unit (IF) and the instruction-execute FSM (IE). It also contains the OAM DMA engine, triggered by a CPU write to $4014, which copies one 256-byte page to the PPU OAM data port while both CPU requesters are stalled. It sits between the IF/IE blocks and the memory map decoder, and replaces direct wiring of the IE-side memory port.

## Interface
- DMA_REG_ADDR, 16'h4014, write address that triggers OAM DMA
- OAM_DATA_ADDR, 16'h2004, DMA write target
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  IF requests bus (read only)
- if_addr  in  16  IF read address
- if_gnt  out  1  IF owns bus this cycle
- ie_req  in  1  IE requests bus
- ie_addr  in  16  IE address
- ie_data_out  in  8  IE write data
- ie_write_en  in  1  IE write strobe
- ie_gnt  out  1  IE owns bus this cycle
- mem_addr  out  16  bus address
- mem_data_out  out  8  bus write data
- mem_write_en  out  1  bus write strobe
- mem_data_in  in  8  bus read data, valid the cycle after its address is driven
- dma_active  out  1  DMA owns bus; CPU stalled

## Operation
- States: IDLE, OWN_IF, OWN_IE, DMA_DUMMY, DMA_ALIGN, DMA_READ, DMA_WRITE.
- Arbitration happens on the edge in IDLE, or in OWN_x when that owner's req is low. Priority: DMA pending > ie_req > if_req > IDLE.
- An owner holds the bus, with its gnt high, for as long as its req stays high. There is no preemption, including by DMA.
- Bus mux is combinational from registered state. OWN_IF drives if_addr, write_en 0, data 0. OWN_IE passes the ie_* signals. DMA states drive internal registers. IDLE drives addr 0, data 0, write_en 0.
- Trigger: in OWN_IE, ie_write_en=1 with ie_addr==DMA_REG_ADDR sets dma_pending and page<=ie_data_out. The write is still forwarded to the bus.
- A trigger while dma_pending is already set overwrites page.
- DMA sequence:
  - DMA_DUMMY: 1 cycle.
  - DMA_ALIGN: 1 cycle, entered only if the parity flop is 1 at entry to DMA_DUMMY.
  - Then 256 pairs. DMA_READ drives {page, idx}, we=0. DMA_WRITE drives OAM_DATA_ADDR, data=mem_data_in, we=1.
  - idx is 8 bits and starts at 0. It increments after each write. Wrap 255->0 ends the DMA.
- After the last DMA_WRITE: dma_pending cleared, dma_active falls, re-arbitrate.
- Parity flop toggles every cycle from reset (reset 0).
- DMA length is 513 cycles at even parity and 514 at odd parity.
- Address arithmetic is 16-bit, no carry beyond the low byte; idx never carries into page.

## Timing
- Reset values: state IDLE, if_gnt 0, ie_gnt 0, dma_active 0, mem_addr 0, mem_data_out 0, mem_write_en 0, dma_pending 0, page 0, idx 0, parity 0.
- Grant latency: req sampled high at edge N gives gnt high during cycle N+1, and the bus carries that requester's signals in the same cycle.
- Release: req low at edge N drops gnt in cycle N+1, and a new owner is granted in that same cycle. There are no dead cycles.
- A trigger write at edge N followed by ie_req low enters DMA_DUMMY at the next arbitration, where dma_active=1.
- Simultaneous if_req and ie_req from IDLE: IE wins. IF is granted when IE releases.
- Requests during DMA are held pending; the requester keeps req high.
- Reset asserted mid-operation, including mid-DMA, aborts immediately to reset values. No partial DMA resumes.

## Configuration
- OAM_DMA_EN defined: DMA engine, parity flop and DMA states are compiled in.
- OAM_DMA_EN undefined:
  - Writes to DMA_REG_ADDR are plain forwarded writes.
  - dma_active is tied 0.
  - Only IDLE/OWN_IF/OWN_IE exist.
  - All other behaviour is identical.

## Test plan
- Reset release, if_req=1 with if_addr=16'hC000 at edge 1 -> if_gnt=1 and mem_addr=C000 in cycle 2, mem_write_en=0.
- if_req and ie_req both high from IDLE, ie_addr=0x0200 -> ie_gnt first. When ie_req drops, if_gnt rises the next cycle with no gap.
- IE writes 0x02 to $4014 at even parity, memory page 0x0200-0x02FF preloaded with i^0x5A -> 256 writes to $2004 with data i^0x5A in order. dma_active is high for exactly 513 cycles.
- Same trigger issued one cycle later (odd parity) -> dma_active is high for 514 cycles and the data sequence is unchanged.
- Reset pulsed after the 100th DMA write -> all outputs return to reset values asynchronously. After release, an if_req is granted normally with no further $2004 writes.
- Built without OAM_DMA_EN, IE writes 0x02 to $4014 -> the single write appears on the bus, dma_active stays 0, and if_gnt follows on the next cycle.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
//   Shares the CPU memory bus between the instruction-fetch unit (IF) and the
//   instruction-execute FSM (IE). When built with OAM_DMA_EN it also contains
//   the OAM DMA engine. A CPU write to $4014 starts that engine, which copies
//   one 256-byte page to the PPU OAM data port ($2004). Both CPU requesters
//   are stalled while the copy runs.
//
//   Build option: define OAM_DMA_EN to compile in the DMA engine. When it is
//   undefined, writes to $4014 are plain forwarded writes and dma_active is 0.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-low reset
//   if_req/if_addr IF read request and address; if_gnt is high while IF owns the bus
//   ie_req/ie_addr/ie_data_out/ie_write_en
//                  IE request, address, write data and write strobe;
//                  ie_gnt is high while IE owns the bus
//   mem_addr/mem_data_out/mem_write_en
//                  bus outputs, decoded combinationally from the registered owner
//   mem_data_in    bus read data, valid the cycle after its address is driven
//   dma_active     DMA owns the bus and the CPU is stalled
module cpu_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  input  logic        ie_req,
  input  logic [15:0] ie_addr,
  input  logic [7:0]  ie_data_out,
  input  logic        ie_write_en,
  output logic        ie_gnt,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_write_en,
  input  logic [7:0]  mem_data_in,
  output logic        dma_active
);

`ifdef OAM_DMA_EN
  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    IDLE, OWN_IF, OWN_IE, DMA_DUMMY, DMA_ALIGN, DMA_READ, DMA_WRITE
  } state_t;
`else
  typedef enum logic [1:0] {IDLE, OWN_IF, OWN_IE} state_t;
`endif

  state_t state;
  state_t cpu_next;
  state_t arb_next;

  // CPU-only arbitration: IE has priority over IF.
  always_comb begin
    if (ie_req)      cpu_next = OWN_IE;
    else if (if_req) cpu_next = OWN_IF;
    else             cpu_next = IDLE;
  end

`ifdef OAM_DMA_EN
  logic       dma_pending;
  logic       parity;
  logic [7:0] page;
  logic [7:0] idx;
  logic       trigger;

  assign trigger = (state == OWN_IE) && ie_write_en && (ie_addr == DMA_REG_ADDR);
  // A trigger on the same edge that IE releases the bus already wins arbitration.
  assign arb_next = (dma_pending || trigger) ? DMA_DUMMY : cpu_next;
`else
  logic unused_mem_data;
  assign unused_mem_data = ^mem_data_in;
  assign arb_next = cpu_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
`ifdef OAM_DMA_EN
      dma_pending <= 1'b0;
      page        <= '0;
      idx         <= '0;
      parity      <= 1'b0;
`endif
    end else begin
`ifdef OAM_DMA_EN
      parity <= ~parity;
      if (trigger) begin
        dma_pending <= 1'b1;
        page        <= ie_data_out;
      end
`endif
      case (state)
        IDLE:   state <= arb_next;
        OWN_IF: if (!if_req) state <= arb_next;
        OWN_IE: if (!ie_req) state <= arb_next;
`ifdef OAM_DMA_EN
        DMA_DUMMY: state <= parity ? DMA_ALIGN : DMA_READ;
        DMA_ALIGN: state <= DMA_READ;
        DMA_READ:  state <= DMA_WRITE;
        DMA_WRITE: begin
          idx <= idx + 8'd1;
          if (idx == 8'hFF) begin
            // Wrap ends the copy; pending is being cleared, so only CPU requesters compete.
            dma_pending <= 1'b0;
            state       <= cpu_next;
          end else begin
            state <= DMA_READ;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    if_gnt       = 1'b0;
    ie_gnt       = 1'b0;
    dma_active   = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    mem_write_en = 1'b0;
    case (state)
      OWN_IF: begin
        if_gnt   = 1'b1;
        mem_addr = if_addr;
      end
      OWN_IE: begin
        ie_gnt       = 1'b1;
        mem_addr     = ie_addr;
        mem_data_out = ie_data_out;
        mem_write_en = ie_write_en;
      end
`ifdef OAM_DMA_EN
      DMA_DUMMY, DMA_ALIGN: dma_active = 1'b1;
      DMA_READ: begin
        dma_active = 1'b1;
        mem_addr   = {page, idx};
      end
      DMA_WRITE: begin
        // Read data for the preceding DMA_READ address arrives this cycle.
        dma_active   = 1'b1;
        mem_addr     = OAM_DATA_ADDR;
        mem_data_out = mem_data_in;
        mem_write_en = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
